seg_scan_capture: RTL and testbench

//  Recovers hex digit values from a multiplexed, active-low 7-segment bus (seg/digit-enable),
//  the reverse of the hex-to-segment path. Sits on a board header or internal scan bus; each

---
 rtl/seg_scan_capture.sv | 141 ++++++++++++++
 tb/tb_seg_scan_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment scan bus.
// Latency: pins stable at edge E0 -> capture at E0+STABLE_CYCLES+1; no backpressure, input is free-running.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    input  logic                      err_clr,
    output logic [4*NUM_DIGITS-1:0]   hex_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      update,
    output logic                      err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {WAIT, TRACK, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [6:0]              seg_meta, s_seg, ref_seg;
    logic [NUM_DIGITS-1:0]   en_meta, s_en, ref_en;
    logic                    s_onehot;
    logic                    match;
    logic [4:0]              dec;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) ones++;
        end
        return ones == 1;
    endfunction

    // Returns {legal, value}; anything outside the 16-glyph table is illegal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = {1'b1, 4'h0};
            7'h79:   decode = {1'b1, 4'h1};
            7'h24:   decode = {1'b1, 4'h2};
            7'h30:   decode = {1'b1, 4'h3};
            7'h19:   decode = {1'b1, 4'h4};
            7'h12:   decode = {1'b1, 4'h5};
            7'h02:   decode = {1'b1, 4'h6};
            7'h78:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h10:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h03:   decode = {1'b1, 4'hB};
            7'h46:   decode = {1'b1, 4'hC};
            7'h21:   decode = {1'b1, 4'hD};
            7'h06:   decode = {1'b1, 4'hE};
            7'h0E:   decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    assign s_onehot = is_onehot(s_en);
    assign match    = (s_en == ref_en) && (s_seg == ref_seg);
    assign dec      = decode(ref_seg);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            seg_meta    <= '0;
            s_seg       <= '0;
            en_meta     <= '0;
            s_en        <= '0;
            ref_seg     <= '0;
            ref_en      <= '0;
            cnt         <= '0;
            state       <= WAIT;
            hex_out     <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            err         <= 1'b0;
        end else begin
            seg_meta <= seg_in;
            s_seg    <= seg_meta;
            en_meta  <= dig_en;
            s_en     <= en_meta;
            update   <= 1'b0;
            // A capture later in this block overrides the clear.
            if (err_clr) err <= 1'b0;

            case (state)
                WAIT: begin
                    if (s_onehot) begin
                        state   <= TRACK;
                        ref_en  <= s_en;
                        ref_seg <= s_seg;
                        cnt     <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                TRACK, DONE: begin
                    if (match) begin
                        if (state == TRACK) begin
                            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                            if (cnt == CNT_CAP) begin
                                state <= DONE;
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    if (ref_en[i]) begin
                                        if (dec[4]) begin
                                            hex_out[4*i +: 4] <= dec[3:0];
                                            digit_valid[i]    <= 1'b1;
                                            update            <= 1'b1;
                                        end else begin
                                            digit_valid[i] <= 1'b0;
                                            err            <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                    end else if (s_onehot) begin
                        state   <= TRACK;
                        ref_en  <= s_en;
                        ref_seg <= s_seg;
                        cnt     <= CNT_ONE;
                    end else begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: glyph table vectors, scan, glitch, error and reset sequences.
module tb_seg_scan_capture;

    localparam int N = 4;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic [6:0]      seg_in;
    logic [N-1:0]    dig_en;
    logic            err_clr;
    logic [4*N-1:0]  hex_out;
    logic [N-1:0]    digit_valid;
    logic            update;
    logic            err;

    always #5 CLOCK_50 = ~CLOCK_50;

    seg_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(8)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .err_clr     (err_clr),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .update      (update),
        .err         (err)
    );

    typedef struct {
        int         d;
        logic [3:0] v;
    } exp_t;

    typedef struct {
        logic [N-1:0] en;
        logic [6:0]   seg;
        int           hold;
        bit           cap;
        logic [3:0]   val;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       vecs[22];
    logic [6:0] glyph[16];
    int         checks  = 0;
    int         errors  = 0;
    int         upd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] en, input logic [6:0] seg, input int n);
        @(negedge CLOCK_50);
        dig_en = en;
        seg_in = seg;
        repeat (n) @(posedge CLOCK_50);
    endtask

    // Inputs already set; the next posedge is E0. Expect one pulse, at E0+9.
    task automatic latency_run(input string name);
        int pulse_at;
        int pulses;
        pulse_at = -1;
        pulses   = 0;
        @(posedge CLOCK_50);
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLOCK_50);
            #1;
            if (update === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk({name, "_latency"}, pulse_at, 9);
        chk({name, "_pulses"}, pulses, 1);
    endtask

    // Scoreboard: every update pulse must match the oldest pending capture.
    always @(negedge CLOCK_50) begin
        if (reset === 1'b0 && update === 1'b1) begin
            upd_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update actual=1 expected=0 hex_out=%0h", hex_out);
            end else begin
                mon_e = sb.pop_front();
                chk("capture_val", {28'd0, hex_out[4*mon_e.d +: 4]}, {28'd0, mon_e.v});
                chk("capture_valid", {31'd0, digit_valid[mon_e.d]}, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] h_snap;
        logic [3:0]  v_snap;
        int          u_snap;

        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{en: 4'(1 << (i % 4)), seg: glyph[i], hold: 10, cap: 1'b1, val: 4'(i)};
        end
        vecs[16] = '{en: 4'b0001, seg: 7'h30, hold: 10, cap: 1'b1, val: 4'h3};
        vecs[17] = '{en: 4'b0010, seg: 7'h12, hold: 10, cap: 1'b1, val: 4'h5};
        vecs[18] = '{en: 4'b0100, seg: 7'h08, hold: 10, cap: 1'b1, val: 4'hA};
        vecs[19] = '{en: 4'b1000, seg: 7'h0E, hold: 10, cap: 1'b1, val: 4'hF};
        vecs[20] = '{en: 4'b0001, seg: 7'h40, hold: 7,  cap: 1'b0, val: 4'h0};
        vecs[21] = '{en: 4'b0001, seg: 7'h40, hold: 8,  cap: 1'b1, val: 4'h0};

        reset   = 1'b1;
        seg_in  = 7'h7F;
        dig_en  = '0;
        err_clr = 1'b0;
        #1;
        chk("reset_hex", {16'd0, hex_out}, 32'd0);
        chk("reset_valid", {28'd0, digit_valid}, 32'd0);
        chk("reset_update", {31'd0, update}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Single digit latency and no repeat capture while held.
        @(negedge CLOCK_50);
        dig_en = 4'b0001;
        seg_in = 7'h24;
        sb.push_back('{d: 0, v: 4'h2});
        latency_run("hold24");
        chk("hold24_valid", {28'd0, digit_valid}, 32'h1);
        drive('0, 7'h7F, 3);

        for (int i = 0; i < 22; i++) begin
            u_snap = upd_cnt;
            if (vecs[i].cap) sb.push_back('{d: $clog2(int'(vecs[i].en)), v: vecs[i].val});
            drive(vecs[i].en, vecs[i].seg, vecs[i].hold);
            drive('0, 7'h7F, 3);
            chk($sformatf("vec%0d_updates", i), upd_cnt - u_snap, vecs[i].cap ? 1 : 0);
            if (i == 15) chk("glyph_hex", {16'd0, hex_out}, 32'hFEDC);
            if (i == 19) begin
                chk("scan_hex", {16'd0, hex_out}, 32'hFA53);
                chk("scan_valid", {28'd0, digit_valid}, 32'hF);
            end
        end
        chk("glitch_hex", {16'd0, hex_out}, 32'hFA50);

        // Pattern changes before becoming stable: only the final value lands.
        u_snap = upd_cnt;
        sb.push_back('{d: 2, v: 4'h5});
        drive(4'b0100, 7'h19, 5);
        drive(4'b0100, 7'h12, 10);
        drive('0, 7'h7F, 3);
        chk("change_updates", upd_cnt - u_snap, 1);
        chk("change_hex", {28'd0, hex_out[11:8]}, 32'h5);

        // Illegal pattern handling and err_clr priority.
        sb.push_back('{d: 1, v: 4'h3});
        drive(4'b0010, 7'h30, 10);
        drive('0, 7'h7F, 3);
        u_snap = upd_cnt;
        drive(4'b0010, 7'h7F, 10);
        drive('0, 7'h7F, 3);
        chk("illegal_err", {31'd0, err}, 32'd1);
        chk("illegal_valid1", {31'd0, digit_valid[1]}, 32'd0);
        chk("illegal_hex1", {28'd0, hex_out[7:4]}, 32'h3);
        chk("illegal_updates", upd_cnt - u_snap, 0);
        @(negedge CLOCK_50);
        err_clr = 1'b1;
        @(negedge CLOCK_50);
        err_clr = 1'b0;
        chk("errclr_alone", {31'd0, err}, 32'd0);
        @(negedge CLOCK_50);
        dig_en = 4'b0010;
        seg_in = 7'h7F;
        repeat (9) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        err_clr = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("errclr_vs_set", {31'd0, err}, 32'd1);
        @(negedge CLOCK_50);
        err_clr = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        err_clr = 1'b1;
        @(negedge CLOCK_50);
        err_clr = 1'b0;
        chk("errclr_held_done", {31'd0, err}, 32'd0);
        drive('0, 7'h7F, 3);

        // Multi-hot and blanking never capture.
        h_snap = hex_out;
        v_snap = digit_valid;
        u_snap = upd_cnt;
        drive(4'b0011, 7'h24, 20);
        drive(4'b0000, 7'h24, 20);
        drive('0, 7'h7F, 3);
        chk("nohot_updates", upd_cnt - u_snap, 0);
        chk("nohot_hex", {16'd0, hex_out}, {16'd0, h_snap});
        chk("nohot_valid", {28'd0, digit_valid}, {28'd0, v_snap});

        // Asynchronous reset mid-track, then a fresh capture after release.
        drive(4'b0001, 7'h24, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_hex", {16'd0, hex_out}, 32'd0);
        chk("midreset_valid", {28'd0, digit_valid}, 32'd0);
        chk("midreset_update", {31'd0, update}, 32'd0);
        chk("midreset_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        sb.push_back('{d: 0, v: 4'h2});
        latency_run("postreset");
        chk("postreset_hex", {16'd0, hex_out}, 32'h0002);
        drive('0, 7'h7F, 3);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
